pulse_sync_ack: RTL and testbench
=================================

PULSE_SYNC_ACK -- requirements
Module: pulse_sync_ack

Interface
REQ-001 Parameter CLR_CYC, default 2, sets the latch-clear pulse length in clocks; legal range 1..15.
REQ-002 Parameter TMO_CYC, default 16, sets the maximum clocks to wait for the latch to drop after a clear; legal range 2..255.
REQ-003 clk_i  input  1  single system clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 latch_i  input  1  held event flag from the upstream pulse latch; asynchronous to clk_i.
REQ-006 latch_clr_o  output  1  clear request to the upstream latch; the integrator ORs it into that latch's rst_i.
REQ-007 evt_o  output  1  single-cycle strobe, one per accepted event.
REQ-008 evt_pend_o  output  1  high while the pending-event count is nonzero.
REQ-009 evt_ack_i  input  1  consumer acknowledge; each high cycle consumes one pending event.
REQ-010 ovf_o  output  1  sticky overflow flag.
REQ-011 stuck_o  output  1  sticky flag: latch failed to clear within TMO_CYC.
REQ-012 evt_cnt_o  output  8  total accepted-event count (see Configuration).

Function
REQ-013 latch_i SHALL pass through a 2-flop synchronizer (s1, s2) before any use; no other logic SHALL sample latch_i.
REQ-014 FSM states SHALL be IDLE, CLEAR, WAIT_LOW.
REQ-015 IDLE: when s2=1, go to CLEAR and pulse evt_o high for exactly that transition cycle.
REQ-016 CLEAR: latch_clr_o high for exactly CLR_CYC consecutive cycles, then go to WAIT_LOW.
REQ-017 WAIT_LOW: latch_clr_o low; when s2=0, go to IDLE.
REQ-018 WAIT_LOW timeout: if s2 stays 1 for TMO_CYC cycles, set stuck_o and re-enter CLEAR. This re-entry SHALL NOT pulse evt_o.
REQ-019 Latency: evt_o SHALL assert in the cycle following the third rising edge at which latch_i is high.
REQ-020 Pending counter: 4 bits.
- Event only: +1.
- evt_ack_i only: -1.
- Event and ack in the same cycle: unchanged.
REQ-021 Pending counter at 15 with an event and no ack: holds 15 and sets ovf_o.
REQ-022 evt_ack_i with the pending counter at 0: ignored, no underflow.
REQ-023 A new latch assertion SHALL NOT be recognised until the FSM has returned to IDLE; a pulse arriving during CLEAR or WAIT_LOW is absorbed by the latch and seen on the next IDLE.

Reset
REQ-024 rst_i high SHALL immediately force:
- FSM to IDLE.
- s1, s2, pending counter, evt_cnt_o and all counters to 0.
- latch_clr_o, evt_o, evt_pend_o, ovf_o and stuck_o to 0.
REQ-025 Reset asserted mid-CLEAR SHALL terminate latch_clr_o at once; no clear cycles are resumed after release.
REQ-026 ovf_o and stuck_o SHALL clear only on rst_i.

Configuration
REQ-027 Macro PULSE_SYNC_CNT_EN defined: evt_cnt_o is an 8-bit counter, incremented on every evt_o, wrapping 255->0.
REQ-028 Macro PULSE_SYNC_CNT_EN undefined: the counter is not built and evt_cnt_o is tied to 0.

Verification
REQ-029 20 ns clock, reset released; 5 ns latch_i pulse held high by a latch model.
- evt_o high for 1 cycle, 3 edges later.
- latch_clr_o high for 2 cycles.
- FSM back to IDLE; evt_pend_o=1.
REQ-030 Three events with no ack -> pending=3; one-cycle ack -> 2; event coincident with ack -> stays 2.
REQ-031 Sixteen events with no ack -> pending saturates at 15 and ovf_o=1; ack at pending 0 -> count stays 0.
REQ-032 latch model ignores clear (latch_i held 1) -> stuck_o=1 after 16 WAIT_LOW cycles; clear re-issued; evt_o pulses once only.
REQ-033 rst_i asserted during the first CLEAR cycle -> latch_clr_o falls the same instant; all outputs 0.
REQ-034 With PULSE_SYNC_CNT_EN: 256 events with acks -> evt_cnt_o wraps to 0. Without the macro: evt_cnt_o stays 0 throughout.

Source files
------------

// File: rtl/pulse_sync_ack.sv
// Synchronises a held event flag from an upstream latch, clears the latch, and keeps a pending count.
// Define PULSE_SYNC_CNT_EN to build the 8-bit accepted-event counter on evt_cnt_o.
module pulse_sync_ack #(
    parameter int unsigned CLR_CYC = 2,
    parameter int unsigned TMO_CYC = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       latch_i,
    output logic       latch_clr_o,
    output logic       evt_o,
    output logic       evt_pend_o,
    input  logic       evt_ack_i,
    output logic       ovf_o,
    output logic       stuck_o,
    output logic [7:0] evt_cnt_o
);

    // CLEAR <-> WAIT_LOW flips two bits, but neither intermediate code is CLEAR,
    // so the decoded clear cannot glitch into the latch's async reset.
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        CLEAR    = 2'b01,
        WAIT_LOW = 2'b10
    } state_t;

    state_t     state, state_n;
    logic       s1, s2;
    logic [3:0] clr_cnt;
    logic [7:0] tmo_cnt;
    logic [3:0] pend;
    logic       evt_n;
    logic       stuck_set;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= latch_i;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            clr_cnt <= '0;
            tmo_cnt <= '0;
            evt_o   <= 1'b0;
            stuck_o <= 1'b0;
        end else begin
            state   <= state_n;
            evt_o   <= evt_n;
            clr_cnt <= (state == CLEAR && state_n == CLEAR) ? clr_cnt + 4'd1 : 4'd0;
            tmo_cnt <= (state == WAIT_LOW && state_n == WAIT_LOW) ? tmo_cnt + 8'd1 : 8'd0;
            if (stuck_set)
                stuck_o <= 1'b1;
        end
    end

    always_comb begin
        state_n   = state;
        evt_n     = 1'b0;
        stuck_set = 1'b0;
        case (state)
            IDLE: begin
                if (s2) begin
                    state_n = CLEAR;
                    evt_n   = 1'b1;
                end
            end
            CLEAR: begin
                if (clr_cnt == 4'(CLR_CYC - 1))
                    state_n = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!s2) begin
                    state_n = IDLE;
                end else if (tmo_cnt == 8'(TMO_CYC - 1)) begin
                    // Latch refused to drop: retry the clear without a new event.
                    state_n   = CLEAR;
                    stuck_set = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign latch_clr_o = (state == CLEAR);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend  <= '0;
            ovf_o <= 1'b0;
        end else if (evt_o && !evt_ack_i) begin
            if (pend == 4'd15)
                ovf_o <= 1'b1;
            else
                pend <= pend + 4'd1;
        end else if (!evt_o && evt_ack_i && pend != 4'd0) begin
            pend <= pend - 4'd1;
        end
    end

    assign evt_pend_o = (pend != 4'd0);

`ifdef PULSE_SYNC_CNT_EN
    logic [7:0] evt_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            evt_cnt <= '0;
        else if (evt_o)
            evt_cnt <= evt_cnt + 8'd1;
    end

    assign evt_cnt_o = evt_cnt;
`else
    assign evt_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pulse_sync_ack.sv
// Directed bench for pulse_sync_ack with a behavioural upstream pulse latch.
module tb_pulse_sync_ack;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       latch;
    logic       latch_clr;
    logic       evt;
    logic       evt_pend;
    logic       evt_ack = 1'b0;
    logic       ovf;
    logic       stuck;
    logic [7:0] evt_cnt;

    logic pulse    = 1'b0;
    logic latch_q  = 1'b0;
    logic force_hi = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    always #10 clk = ~clk;

    // Upstream latch: set by a short pulse, cleared asynchronously by the DUT's clear.
    always @(posedge pulse or posedge latch_clr)
        if (latch_clr) latch_q <= 1'b0;
        else           latch_q <= 1'b1;

    assign latch = force_hi | latch_q;

    pulse_sync_ack #(.CLR_CYC(2), .TMO_CYC(16)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .latch_i     (latch),
        .latch_clr_o (latch_clr),
        .evt_o       (evt),
        .evt_pend_o  (evt_pend),
        .evt_ack_i   (evt_ack),
        .ovf_o       (ovf),
        .stuck_o     (stuck),
        .evt_cnt_o   (evt_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic fire();
        @(negedge clk);
        pulse = 1'b1;
        #5 pulse = 1'b0;
    endtask

    // One latch pulse, then eight cycles observing evt_o; optionally ack the same cycle.
    task automatic event_cycle(input bit ack_with_evt, output int n_evt);
        n_evt = 0;
        fire();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            evt_ack = 1'b0;
            if (evt === 1'b1) begin
                n_evt++;
                if (ack_with_evt) evt_ack = 1'b1;
            end
        end
        @(negedge clk);
        evt_ack = 1'b0;
    endtask

    task automatic ack_cycle();
        @(negedge clk);
        evt_ack = 1'b1;
        @(negedge clk);
        evt_ack = 1'b0;
    endtask

    initial begin
        int n, tot;

        // Reset state
        #15;
        check("rst_clr",   latch_clr, 1'b0);
        check("rst_evt",   evt,       1'b0);
        check("rst_pend",  evt_pend,  1'b0);
        check("rst_ovf",   ovf,       1'b0);
        check("rst_stuck", stuck,     1'b0);
        check("rst_cnt",   evt_cnt,   8'd0);
        do_reset();

        // Basic latency: evt_o after third edge, clear for two cycles
        fire();
        @(negedge clk); check("lat_e1_evt", evt, 1'b0);
        @(negedge clk); check("lat_e2_evt", evt, 1'b0);
        @(negedge clk); check("lat_e3_evt", evt, 1'b1);
                        check("lat_e3_clr", latch_clr, 1'b1);
        @(negedge clk); check("lat_e4_evt", evt, 1'b0);
                        check("lat_e4_clr", latch_clr, 1'b1);
                        check("lat_e4_pend", evt_pend, 1'b1);
        @(negedge clk); check("lat_e5_clr", latch_clr, 1'b0);
        repeat (4) @(negedge clk);
        check("lat_idle_clr",  latch_clr, 1'b0);
        check("lat_idle_pend", evt_pend,  1'b1);
        check("lat_idle_evt",  evt,       1'b0);
        ack_cycle();
        check("lat_ack_pend", evt_pend, 1'b0);

        // Three events, one ack, coincident event+ack -> two pending
        tot = 0;
        repeat (3) begin
            event_cycle(1'b0, n);
            tot += n;
        end
        check("p3_evts", tot, 3);
        ack_cycle();
        event_cycle(1'b1, n);
        check("p3_coinc_evt", n, 1);
        ack_cycle();
        check("p2_after1ack", evt_pend, 1'b1);
        ack_cycle();
        check("p2_after2ack", evt_pend, 1'b0);
        check("p_no_ovf", ovf, 1'b0);
`ifndef PULSE_SYNC_CNT_EN
        check("cnt_off_a", evt_cnt, 8'd0);
`endif

        // Saturation at 15 and sticky overflow
        do_reset();
        tot = 0;
        repeat (15) begin
            event_cycle(1'b0, n);
            tot += n;
        end
        check("sat15_evts", tot, 15);
        check("sat15_ovf", ovf, 1'b0);
        event_cycle(1'b0, n);
        check("sat16_ovf", ovf, 1'b1);
        repeat (14) ack_cycle();
        check("sat_14ack_pend", evt_pend, 1'b1);
        ack_cycle();
        check("sat_15ack_pend", evt_pend, 1'b0);
        ack_cycle();
        check("undf_pend", evt_pend, 1'b0);
        event_cycle(1'b0, n);
        check("undf_evt_pend", evt_pend, 1'b1);
        ack_cycle();
        check("undf_ack_pend", evt_pend, 1'b0);
        check("ovf_sticky", ovf, 1'b1);
`ifndef PULSE_SYNC_CNT_EN
        check("cnt_off_b", evt_cnt, 8'd0);
`endif

        // Latch ignores clear -> timeout, re-clear, single evt_o
        do_reset();
        @(negedge clk);
        force_hi = 1'b1;
        tot = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (evt === 1'b1) tot++;
            if (i == 20) check("stk_e20_stuck", stuck, 1'b0);
            if (i == 21) begin
                check("stk_e21_stuck", stuck, 1'b1);
                check("stk_e21_clr", latch_clr, 1'b1);
            end
        end
        force_hi = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (evt === 1'b1) tot++;
        end
        check("stk_evt_once", tot, 1);
        check("stk_sticky", stuck, 1'b1);
        check("stk_clr_done", latch_clr, 1'b0);

        // Reset during the first CLEAR cycle
        do_reset();
        fire();
        repeat (3) @(negedge clk);
        check("rc_clr_pre", latch_clr, 1'b1);
        rst = 1'b1;
        #1;
        check("rc_clr",  latch_clr, 1'b0);
        check("rc_evt",  evt,       1'b0);
        check("rc_pend", evt_pend,  1'b0);
        check("rc_stk",  {ovf, stuck}, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        tot = 0;
        repeat (8) begin
            @(negedge clk);
            if (latch_clr === 1'b1 || evt === 1'b1) tot++;
        end
        check("rc_no_resume", tot, 0);

`ifdef PULSE_SYNC_CNT_EN
        // 256 acked events wrap the counter
        do_reset();
        event_cycle(1'b1, n);
        check("cnt_1", evt_cnt, 8'd1);
        repeat (254) event_cycle(1'b1, n);
        check("cnt_255", evt_cnt, 8'd255);
        event_cycle(1'b1, n);
        check("cnt_wrap", evt_cnt, 8'd0);
        check("cnt_pend", evt_pend, 1'b0);
`else
        event_cycle(1'b1, n);
        check("cnt_off_c", evt_cnt, 8'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
